// File: rtl/ingress_action_merge.sv
// ingress_action_merge: holds each packet until its classification action arrives, then drops it or rewrites its output port and forwards it
module ingress_action_merge_fifo #(
    parameter int W  = 8,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr,
    input  logic [W-1:0]  d,
    input  logic          rd,
    output logic [W-1:0]  q,
    output logic          empty,
    output logic [AW:0]   usedw
);
    logic [W-1:0] mem [2**AW];
    logic [AW:0]  wp, rp;
    logic         wr_en, rd_en;
    assign usedw = wp - rp;
    assign empty = wp == rp;
    assign wr_en = wr && !usedw[AW];
    assign rd_en = rd && !empty;
    assign q     = mem[rp[AW-1:0]];
    // storage array; pointers alone decide which entries are live
    always_ff @(posedge clk)
        if (wr_en) mem[wp[AW-1:0]] <= d;
    // read/write pointers, cleared by reset so the fifo empties at once
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (wr_en) wp <= wp + 1'b1;
            if (rd_en) rp <= rp + 1'b1;
        end
endmodule

module ingress_action_merge #(
    parameter int PKT_AFULL_TH = 128,
    parameter int ACT_AFULL_TH = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_ingress_pkt_wr,
    input  logic [133:0] in_ingress_pkt,
    input  logic         in_ingress_valid_wr,
    input  logic         in_ingress_valid,
    output logic         out_ingress_pkt_almostfull,
    input  logic         in_class_action_wr,
    input  logic [15:0]  in_class_action,
    output logic         out_class_action_almostfull,
    output logic         out_egress_pkt_wr,
    output logic [133:0] out_egress_pkt,
    output logic         out_egress_valid_wr,
    output logic         out_egress_valid,
    input  logic         in_egress_pkt_almostfull,
    output logic [31:0]  out_fwd_cnt,
    output logic [31:0]  out_drop_cnt
);
    localparam logic [8:0] PKT_TH = 9'(PKT_AFULL_TH);
    localparam logic [6:0] ACT_TH = 7'(ACT_AFULL_TH);

    typedef enum logic [1:0] {IDLE, META1, FWD, DISC} state_t;
    state_t state, state_nxt;

    logic [133:0] pkt_q, emit_word;
    logic [8:0]   pkt_usedw;
    logic         pkt_empty, pkt_rd;
    logic         valid_q, valid_empty, valid_rd;
    logic [6:0]   valid_usedw_unused;
    logic [15:0]  act_q;
    logic [6:0]   act_usedw;
    logic         act_empty, act_rd;
    logic [7:0]   act_port;
    logic         emit, fwd_inc, drop_inc, is_tail;
    logic         act_bits_unused;

    ingress_action_merge_fifo #(.W(134), .AW(8)) u_pkt_fifo (
        .clk   (clk),
        .reset (reset),
        .wr    (in_ingress_pkt_wr),
        .d     (in_ingress_pkt),
        .rd    (pkt_rd),
        .q     (pkt_q),
        .empty (pkt_empty),
        .usedw (pkt_usedw)
    );

    ingress_action_merge_fifo #(.W(1), .AW(6)) u_valid_fifo (
        .clk   (clk),
        .reset (reset),
        .wr    (in_ingress_valid_wr),
        .d     (in_ingress_valid),
        .rd    (valid_rd),
        .q     (valid_q),
        .empty (valid_empty),
        .usedw (valid_usedw_unused)
    );

    ingress_action_merge_fifo #(.W(16), .AW(6)) u_act_fifo (
        .clk   (clk),
        .reset (reset),
        .wr    (in_class_action_wr),
        .d     (in_class_action),
        .rd    (act_rd),
        .q     (act_q),
        .empty (act_empty),
        .usedw (act_usedw)
    );

    assign out_ingress_pkt_almostfull  = pkt_usedw >= PKT_TH;
    assign out_class_action_almostfull = act_usedw >= ACT_TH;
    assign is_tail                     = pkt_q[133:132] == 2'b10;
    assign act_bits_unused             = ^act_q[14:8];

    // packet scheduler: picks the fate of the next packet in IDLE, then streams or discards it to the tail
    always_comb begin
        state_nxt = state;
        pkt_rd    = 1'b0;
        valid_rd  = 1'b0;
        act_rd    = 1'b0;
        emit      = 1'b0;
        fwd_inc   = 1'b0;
        drop_inc  = 1'b0;
        emit_word = pkt_q;
        case (state)
            IDLE: begin
                if (!valid_empty && !valid_q) begin
                    valid_rd  = 1'b1;
                    drop_inc  = 1'b1;
                    state_nxt = DISC;
                end else if (!valid_empty && !act_empty && !in_egress_pkt_almostfull) begin
                    valid_rd  = 1'b1;
                    act_rd    = 1'b1;
                    drop_inc  = act_q[15];
                    state_nxt = act_q[15] ? DISC : META1;
                end
            end
            META1: begin
                if (!pkt_empty) begin
                    pkt_rd    = 1'b1;
                    emit      = 1'b1;
                    emit_word = {pkt_q[133:128], act_port, pkt_q[119:0]};
                    state_nxt = FWD;
                end
            end
            FWD: begin
                if (!pkt_empty) begin
                    pkt_rd    = 1'b1;
                    emit      = 1'b1;
                    fwd_inc   = is_tail;
                    state_nxt = is_tail ? IDLE : FWD;
                end
            end
            DISC: begin
                if (!pkt_empty) begin
                    pkt_rd    = 1'b1;
                    state_nxt = is_tail ? IDLE : DISC;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // state, latched action port, registered egress outputs and packet counters
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state               <= IDLE;
            act_port            <= '0;
            out_egress_pkt_wr   <= 1'b0;
            out_egress_pkt      <= '0;
            out_egress_valid_wr <= 1'b0;
            out_egress_valid    <= 1'b0;
            out_fwd_cnt         <= '0;
            out_drop_cnt        <= '0;
        end else begin
            state               <= state_nxt;
            out_egress_pkt_wr   <= emit;
            out_egress_valid_wr <= fwd_inc;
            out_egress_valid    <= fwd_inc;
            if (act_rd) act_port <= act_q[7:0];
            if (emit) out_egress_pkt <= emit_word;
            if (fwd_inc) out_fwd_cnt <= out_fwd_cnt + 32'd1;
            if (drop_inc) out_drop_cnt <= out_drop_cnt + 32'd1;
        end
endmodule

// File: tb/tb_ingress_action_merge.sv
// tb_ingress_action_merge: scoreboard bench for the packet/action merge stage
module tb_ingress_action_merge;
    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         in_ingress_pkt_wr = 1'b0;
    logic [133:0] in_ingress_pkt = '0;
    logic         in_ingress_valid_wr = 1'b0;
    logic         in_ingress_valid = 1'b0;
    logic         out_ingress_pkt_almostfull;
    logic         in_class_action_wr = 1'b0;
    logic [15:0]  in_class_action = '0;
    logic         out_class_action_almostfull;
    logic         out_egress_pkt_wr;
    logic [133:0] out_egress_pkt;
    logic         out_egress_valid_wr;
    logic         out_egress_valid;
    logic         in_egress_pkt_almostfull = 1'b0;
    logic [31:0]  out_fwd_cnt;
    logic [31:0]  out_drop_cnt;

    typedef struct {
        logic [133:0] w;
        logic         last;
    } exp_t;

    exp_t         exp_q[$];
    exp_t         mon_e;
    logic [133:0] cur_pkt[$];
    int           n_checks = 0;
    int           n_errors = 0;

    ingress_action_merge dut (
        .clk                         (clk),
        .reset                       (reset),
        .in_ingress_pkt_wr           (in_ingress_pkt_wr),
        .in_ingress_pkt              (in_ingress_pkt),
        .in_ingress_valid_wr         (in_ingress_valid_wr),
        .in_ingress_valid            (in_ingress_valid),
        .out_ingress_pkt_almostfull  (out_ingress_pkt_almostfull),
        .in_class_action_wr          (in_class_action_wr),
        .in_class_action             (in_class_action),
        .out_class_action_almostfull (out_class_action_almostfull),
        .out_egress_pkt_wr           (out_egress_pkt_wr),
        .out_egress_pkt              (out_egress_pkt),
        .out_egress_valid_wr         (out_egress_valid_wr),
        .out_egress_valid            (out_egress_valid),
        .in_egress_pkt_almostfull    (in_egress_pkt_almostfull),
        .out_fwd_cnt                 (out_fwd_cnt),
        .out_drop_cnt                (out_drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [133:0] got, input logic [133:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // egress monitor: every emitted word must match the head of the scoreboard
    always @(negedge clk) begin
        if (out_egress_pkt_wr) begin
            if (exp_q.size() == 0) begin
                check("egress_unexpected", 134'(out_egress_pkt_wr), 134'(0));
            end else begin
                mon_e = exp_q.pop_front();
                check("egress_word", out_egress_pkt, mon_e.w);
                check("egress_valid_wr", 134'(out_egress_valid_wr), 134'(mon_e.last));
                if (mon_e.last) check("egress_valid", 134'(out_egress_valid), 134'(1));
            end
        end else if (out_egress_valid_wr) begin
            check("valid_wr_orphan", 134'(out_egress_valid_wr), 134'(0));
        end
    end

    task automatic send_pkt(input int n, input logic vld);
        logic [133:0] w;
        logic [1:0]   tag;
        cur_pkt.delete();
        for (int i = 0; i < n; i++) begin
            tag = (i == 0) ? 2'b01 : (i == n - 1) ? 2'b10 : 2'b11;
            w = {tag, (i == n - 1) ? 4'h5 : 4'hF, $urandom(), $urandom(), $urandom(), $urandom()};
            cur_pkt.push_back(w);
            @(negedge clk);
            in_ingress_pkt_wr   = 1'b1;
            in_ingress_pkt      = w;
            in_ingress_valid_wr = (i == n - 1);
            in_ingress_valid    = vld;
        end
        @(negedge clk);
        in_ingress_pkt_wr   = 1'b0;
        in_ingress_valid_wr = 1'b0;
    endtask

    task automatic send_act(input logic [15:0] a);
        exp_t e;
        @(negedge clk);
        in_class_action_wr = 1'b1;
        in_class_action    = a;
        if (!a[15]) begin
            foreach (cur_pkt[i]) begin
                e.w = cur_pkt[i];
                if (i == 0) e.w[127:120] = a[7:0];
                e.last = (i == cur_pkt.size() - 1);
                exp_q.push_back(e);
            end
        end
        @(negedge clk);
        in_class_action_wr = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 300) begin
            @(negedge clk);
            t++;
        end
        check("drain_timeout", 134'(exp_q.size()), 134'(0));
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        repeat (3) @(negedge clk);
        check("rst_egress_wr", 134'(out_egress_pkt_wr), 134'(0));
        check("rst_egress_pkt", out_egress_pkt, 134'(0));
        check("rst_valid_wr", 134'(out_egress_valid_wr), 134'(0));
        check("rst_pkt_afull", 134'(out_ingress_pkt_almostfull), 134'(0));
        check("rst_fwd_cnt", 134'(out_fwd_cnt), 134'(0));
        check("rst_drop_cnt", 134'(out_drop_cnt), 134'(0));
        reset = 1'b1;
        repeat (2) @(negedge clk);

        send_pkt(4, 1'b1);
        send_act(16'h0005);
        drain();
        check("t1_fwd_cnt", 134'(out_fwd_cnt), 134'(1));

        send_pkt(5, 1'b1);
        send_act(16'h8000);
        send_pkt(3, 1'b1);
        send_act(16'h0003);
        drain();
        check("t2_drop_cnt", 134'(out_drop_cnt), 134'(1));
        check("t2_fwd_cnt", 134'(out_fwd_cnt), 134'(2));

        send_pkt(4, 1'b0);
        send_pkt(6, 1'b1);
        send_act(16'h0002);
        drain();
        check("t3_drop_cnt", 134'(out_drop_cnt), 134'(2));
        check("t3_fwd_cnt", 134'(out_fwd_cnt), 134'(3));

        send_pkt(4, 1'b1);
        repeat (50) @(negedge clk);
        check("t4_no_early_fwd", 134'(out_fwd_cnt), 134'(3));
        send_act(16'h0007);
        lat = 0;
        while (!out_egress_pkt_wr && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("t4_act_to_egress", 134'(lat), 134'(2));
        drain();
        check("t4_fwd_cnt", 134'(out_fwd_cnt), 134'(4));

        @(negedge clk);
        in_egress_pkt_almostfull = 1'b1;
        send_pkt(4, 1'b1);
        send_act(16'h0004);
        repeat (20) @(negedge clk);
        check("t5_bp_hold_q", 134'(exp_q.size()), 134'(4));
        check("t5_bp_hold_cnt", 134'(out_fwd_cnt), 134'(4));
        in_egress_pkt_almostfull = 1'b0;
        drain();
        check("t5_fwd_cnt", 134'(out_fwd_cnt), 134'(5));
        send_pkt(8, 1'b1);
        send_act(16'h0006);
        lat = 0;
        while (!out_egress_pkt_wr && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        check("t5_midpkt_start", 134'(out_egress_pkt_wr), 134'(1));
        in_egress_pkt_almostfull = 1'b1;
        drain();
        check("t5_midpkt_fwd_cnt", 134'(out_fwd_cnt), 134'(6));
        in_egress_pkt_almostfull = 1'b0;

        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            if (i == 31) check("t6_act_afull_31", 134'(out_class_action_almostfull), 134'(0));
            in_class_action_wr = 1'b1;
            in_class_action    = 16'h00AA;
        end
        @(negedge clk);
        in_class_action_wr = 1'b0;
        check("t6_act_afull_32", 134'(out_class_action_almostfull), 134'(1));
        for (int i = 0; i < 128; i++) begin
            @(negedge clk);
            if (i == 127) check("t6_pkt_afull_127", 134'(out_ingress_pkt_almostfull), 134'(0));
            in_ingress_pkt_wr = 1'b1;
            in_ingress_pkt    = {(i == 0) ? 2'b01 : 2'b11, 4'hF, 128'(i)};
        end
        @(negedge clk);
        in_ingress_pkt_wr = 1'b0;
        check("t6_pkt_afull_128", 134'(out_ingress_pkt_almostfull), 134'(1));

        reset = 1'b0;
        #1;
        check("t6_rst_pkt_afull", 134'(out_ingress_pkt_almostfull), 134'(0));
        check("t6_rst_act_afull", 134'(out_class_action_almostfull), 134'(0));
        check("t6_rst_egress_pkt", out_egress_pkt, 134'(0));
        check("t6_rst_fwd_cnt", 134'(out_fwd_cnt), 134'(0));
        check("t6_rst_drop_cnt", 134'(out_drop_cnt), 134'(0));
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        send_pkt(3, 1'b1);
        send_act(16'h0011);
        drain();
        check("t6_post_rst_fwd", 134'(out_fwd_cnt), 134'(1));
        check("t6_post_rst_drop", 134'(out_drop_cnt), 134'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
